// File: rtl/quad_db_pkg.sv
// Shared types and constants for the quadrature input debouncer.
package quad_db_pkg;

  // Filter FSM state for one pin.
  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_t;

  // Filter length for 1 ms at a 50 MHz system clock.
  localparam int unsigned DB_CYCLES_1MS = 50000;

endpackage

// File: rtl/db_channel.sv
// One pin: two-flop synchroniser, stable-time filter FSM and edge strobe.
//
// state      | meaning
// DB_STABLE  | synchronised level matches db_q, counter idle at 0
// DB_PENDING | level differs from db_q, counting consecutive mismatching edges
module db_channel
  import quad_db_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_1MS
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic db_o,
  output logic edge_o
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  // With a one-cycle filter a mismatch is accepted straight from DB_STABLE.
  localparam bit SINGLE = (DB_CYCLES == 1);
  // Count value on which the next mismatching edge completes the filter.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             edge_q, edge_d;
  logic             mismatch;
  logic             flip;

  assign mismatch = (s2_q != db_q);

  // State register: synchroniser, FSM, counter, accepted level and strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      db_q    <= 1'b1;
      edge_q  <= 1'b0;
    end else begin
      s1_q    <= pin_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      edge_q  <= edge_d;
    end
  end

  // Next-state logic: any match while pending is bounce and drops back to stable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DB_STABLE:  if (mismatch && !SINGLE) state_d = DB_PENDING;
      DB_PENDING: if (!mismatch || (cnt_q == CNT_LAST)) state_d = DB_STABLE;
      default:    state_d = DB_STABLE;
    endcase
  end

  // Output logic: counter update, level flip and strobe request.
  always_comb begin
    flip  = 1'b0;
    cnt_d = '0;
    case (state_q)
      DB_STABLE: begin
        if (mismatch) begin
          if (SINGLE) flip = 1'b1;
          else        cnt_d = CNT_W'(1);
        end
      end
      DB_PENDING: begin
        if (mismatch) begin
          if (cnt_q == CNT_LAST) flip = 1'b1;
          else                   cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    db_d   = db_q ^ flip;
    edge_d = flip;
  end

  assign db_o   = db_q;
  assign edge_o = edge_q;

endmodule

// File: rtl/quad_debounce.sv
// Debounces both encoder pins and flags illegal simultaneous A/B steps.
module quad_debounce
  import quad_db_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_1MS,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             a_db,
  output logic             b_db,
  output logic             a_edge,
  output logic             b_edge,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  db_channel #(.DB_CYCLES(DB_CYCLES)) u_ch_a (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (a),
    .db_o   (a_db),
    .edge_o (a_edge)
  );

  db_channel #(.DB_CYCLES(DB_CYCLES)) u_ch_b (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (b),
    .db_o   (b_db),
    .edge_o (b_edge)
  );

  // Both strobes together mean a skipped Gray step; downstream still sees both edges.
  assign err = a_edge & b_edge;

  // Saturating error count, held at all-ones once reached.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_quad_debounce.sv
// Directed bench for quad_debounce with DB_CYCLES = 4, ERR_W = 3.
module tb_quad_debounce;

  localparam int DBC = 4;
  localparam int EW  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          a, b;
  logic          a_db, b_db, a_edge, b_edge, err;
  logic [EW-1:0] err_count;

  int checks   = 0;
  int failures = 0;

  int w_a_cnt, w_b_cnt, w_err_cnt;
  int w_a_first, w_b_first, w_err_first;
  int bounce_edges;
  int exp_errs;
  int exp_sat;

  logic [1:0] quad_seq [4];
  int         quad_a   [4];

  quad_debounce #(.DB_CYCLES(DBC), .ERR_W(EW)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .a_db      (a_db),
    .b_db      (b_db),
    .a_edge    (a_edge),
    .b_edge    (b_edge),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n clock edges; edge i is the i-th edge after the call. Records strobe
  // counts and the first edge index on which each strobe was seen.
  task automatic watch(input int n);
    w_a_cnt = 0; w_b_cnt = 0; w_err_cnt = 0;
    w_a_first = 0; w_b_first = 0; w_err_first = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (a_edge) begin w_a_cnt++; if (w_a_first == 0) w_a_first = i; end
      if (b_edge) begin w_b_cnt++; if (w_b_first == 0) w_b_first = i; end
      if (err)    begin w_err_cnt++; if (w_err_first == 0) w_err_first = i; end
    end
  endtask

  initial begin
    quad_seq[0] = 2'b01; quad_a[0] = 1;
    quad_seq[1] = 2'b00; quad_a[1] = 0;
    quad_seq[2] = 2'b10; quad_a[2] = 1;
    quad_seq[3] = 2'b11; quad_a[3] = 0;

    // 1. Reset with a low, then release
    reset = 1'b1; a = 1'b0; b = 1'b1;
    repeat (3) tick();
    check("rst_a_db", a_db, 1);
    check("rst_b_db", b_db, 1);
    check("rst_a_edge", a_edge, 0);
    check("rst_b_edge", b_edge, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    reset = 1'b0;
    watch(10);
    check("rel_a_edge_at", w_a_first, 6);
    check("rel_a_edge_cnt", w_a_cnt, 1);
    check("rel_b_edge_cnt", w_b_cnt, 0);
    check("rel_a_db", a_db, 0);

    // 2. Clean step 1->0
    a = 1'b1;
    watch(10);
    check("step_rise_a_db", a_db, 1);
    a = 1'b0;
    watch(10);
    check("step_a_edge_at", w_a_first, 6);
    check("step_a_edge_cnt", w_a_cnt, 1);
    check("step_b_edge_cnt", w_b_cnt, 0);
    check("step_a_db", a_db, 0);
    check("step_b_db", b_db, 1);

    // 3. Bounce with 2-cycle pulses, then settle low
    a = 1'b1;
    watch(10);
    check("bnc_pre_a_db", a_db, 1);
    bounce_edges = 0;
    for (int i = 0; i < 5; i++) begin
      a = 1'b0; watch(2); bounce_edges += w_a_cnt;
      a = 1'b1; watch(2); bounce_edges += w_a_cnt;
    end
    check("bnc_no_edge", bounce_edges, 0);
    check("bnc_a_db_held", a_db, 1);
    a = 1'b0;
    watch(10);
    check("bnc_settle_at", w_a_first, 6);
    check("bnc_settle_cnt", w_a_cnt, 1);

    // 4. Clockwise quadrature sequence, 12-cycle dwell
    a = 1'b1;
    watch(10);
    for (int i = 0; i < 4; i++) begin
      {a, b} = quad_seq[i];
      watch(12);
      check($sformatf("quad%0d_a_cnt", i), w_a_cnt, quad_a[i]);
      check($sformatf("quad%0d_b_cnt", i), w_b_cnt, 1 - quad_a[i]);
      check($sformatf("quad%0d_edge_at", i), quad_a[i] ? w_a_first : w_b_first, 6);
      check($sformatf("quad%0d_err", i), w_err_cnt, 0);
      check($sformatf("quad%0d_levels", i), {a_db, b_db}, quad_seq[i]);
    end
    check("quad_err_count", err_count, 0);

    // 5. Simultaneous steps; every change of both pins is an error
    exp_errs = 0;
    for (int t = 0; t < 17; t++) begin
      {a, b} = (t % 2 == 0) ? 2'b00 : 2'b11;
      watch(10);
      exp_errs++;
      exp_sat = (exp_errs > 7) ? 7 : exp_errs;
      check($sformatf("ill%0d_err_cnt", t), w_err_cnt, 1);
      check($sformatf("ill%0d_err_at", t), w_err_first, 6);
      check($sformatf("ill%0d_ab_at", t), {w_a_first[7:0], w_b_first[7:0]}, {8'd6, 8'd6});
      check($sformatf("ill%0d_err_count", t), err_count, exp_sat);
    end

    // 6. Reset while a transition is pending
    {a, b} = 2'b11;
    watch(10);
    check("mid_pre_levels", {a_db, b_db}, 2'b11);
    a = 1'b0;
    watch(4);
    check("mid_no_early_edge", w_a_cnt, 0);
    reset = 1'b1;
    watch(2);
    check("mid_rst_a_edge", w_a_cnt, 0);
    check("mid_rst_a_db", a_db, 1);
    check("mid_rst_err_count", err_count, 0);
    reset = 1'b0;
    watch(10);
    check("mid_rel_edge_at", w_a_first, 6);
    check("mid_rel_edge_cnt", w_a_cnt, 1);
    check("mid_rel_a_db", a_db, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_debounce.md
# quad_debounce

Input conditioning stage for one rotary encoder. It synchronises the raw, pulled-up quadrature pins A and B to the system clock, rejects contact bounce with a per-pin stable-time filter, and presents clean levels (`a_db`, `b_db`) plus one-cycle edge strobes to the downstream `encoder` quadrature decoder. Two instances sit in the lab top level, one per encoder, between the package pins and the decoders.

## Interface
Parameters:
- `DB_CYCLES`, default 50000: number of consecutive clock edges a changed level must persist before it is accepted (1 ms at 50 MHz). Legal range is 1 to 2^20.
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  system clock, CLOCK_50 at top level.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `a`  in  1  raw encoder pin A, asynchronous, idles high.
- `b`  in  1  raw encoder pin B, asynchronous, idles high.
- `a_db`  out  1  debounced, synchronised A.
- `b_db`  out  1  debounced, synchronised B.
- `a_edge`  out  1  one-cycle strobe when `a_db` changes.
- `b_edge`  out  1  one-cycle strobe when `b_db` changes.
- `err`  out  1  one-cycle strobe when `a_db` and `b_db` change on the same edge (illegal Gray step).
- `err_count`  out  ERR_W  saturating count of `err` strobes.

## Operation
- **Synchroniser.** Each pin passes through 2 flip-flops (`s1` then `s2`). Both flip-flops reset to 1.
- **Per-pin filter FSM**, states `DB_STABLE` and `DB_PENDING`. Each pin has a counter of width clog2(DB_CYCLES+1).
  - `DB_STABLE`: if `s2 == db`, hold with count 0. If `s2 != db`: when DB_CYCLES == 1, flip `db` and stay in `DB_STABLE`; otherwise count becomes 1 and the FSM moves to `DB_PENDING`.
  - `DB_PENDING`: if `s2 == db`, this is bounce; return to `DB_STABLE` with count 0 and `db` unchanged. Otherwise count increments. On the edge where the count would reach DB_CYCLES, flip `db`, clear count, and return to `DB_STABLE`.
- **Edge strobes.** `x_edge` is registered and is high exactly in the cycle following the edge that flipped `x_db`. It is never high for 2 consecutive cycles while DB_CYCLES ≥ 2.
- **Error strobe.** `err` is high in the same cycle as `a_edge && b_edge`. `err_count` increments on each such cycle and saturates at 2^ERR_W − 1. It never wraps.
- **Simultaneous-edge handling.** When both pins flip together, the strobes still fire and `a_db`/`b_db` still update. Downstream decides what to do with the step.
- **Reset values** (all outputs and state, including a reset asserted mid-operation):
  - `a_db` = `b_db` = 1.
  - `a_edge` = `b_edge` = `err` = 0.
  - `err_count` = 0.
  - FSMs in `DB_STABLE`, counters 0.
  - A pending transition is discarded.

## Timing
- **Latency.** A new level first sampled by `s1` at edge k appears in `s2` after edge k+1. `x_db` flips on edge k+1+DB_CYCLES, provided the level is held. The strobe is high during the cycle after that edge.
- **Bounce rejection.** Any return to the old level before the DB_CYCLES-th mismatching edge restarts the count from zero. Pulses shorter than DB_CYCLES cycles in `s2` therefore never propagate.
- **Release timing.** After `reset` deasserts, the first mismatch can be counted no earlier than 2 edges later, once the synchroniser has refilled.
- **Throughput.** Sustained toggling with a period of at least 2·DB_CYCLES cycles is tracked with no missed transitions.

## Structure
- **Shared package `quad_db_pkg`** holds:
  - `typedef enum logic {DB_STABLE, DB_PENDING} db_state_t`
  - the localparam `DB_CYCLES_1MS = 50000`
- **Sub-module `db_channel`**: one pin's synchroniser, FSM, counter, and edge strobe, parameterised by DB_CYCLES. It is instantiated twice.
- **Top of `quad_debounce`** holds the `err` and `err_count` logic.

## Test plan
All scenarios use DB_CYCLES = 4 and ERR_W = 3.
1. **Reset.** Hold `reset` 3 cycles with `a` = 0 → `a_db` = `b_db` = 1, strobes 0, `err_count` = 0. After release, `a_db` falls on edge 6 after release with `a_edge` = 1 for one cycle.
2. **Clean step.** `a` 1→0 first sampled at edge 10 and held → `a_db` = 0 after edge 15, `a_edge` high exactly in cycle 15–16, `b_db` unchanged.
3. **Bounce.** `a` toggles 0/1 every 2 cycles for 20 cycles, then settles at 0 → no `a_edge` during the bounce. `a_db` falls 5 edges after the settled level is first sampled.
4. **Quadrature sequence.** Drive a clockwise sequence A,B = 11→01→00→10→11 with 12-cycle dwell → four single strobes alternating a/b, `err` never asserted.
5. **Illegal step.** `a` and `b` both 1→0 on the same edge → `a_edge`, `b_edge` and `err` all high in the same cycle, `err_count` = 1. Repeat 9 times → `err_count` saturates at 7.
6. **Reset mid-filter.** `a` = 0 held, assert `reset` 2 edges after the first mismatch is counted → `a_db` stays 1, no strobe. After release, the full latency restarts.
